deserial: RTL and testbench
===========================

# deserial

Serial-to-parallel converter: accumulates a strobed, LSB-first bit stream into `p_width`-bit words and presents each word on a valid/ready output holding stage. It sits directly downstream of the `serial` shifter, or downstream of any link carrying its bit/strobe pair. Word boundaries come from a frame-sync input. Misalignment and overrun are flagged with single-cycle pulses.

## Interface
- `p_width`, 8: word width in bits; must be at least 2.
- `p_frm`, 0: framing mode. 0 means a single `i_syn` locks framing, after which it free-runs. 1 means every word must start with `i_syn`.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-low.
- `i_val`  in  1  serial data bit; sampled only when `i_stp`=1.
- `i_stp`  in  1  bit strobe; one bit per cycle in which it is high.
- `i_syn`  in  1  frame sync; qualified by `i_stp`; marks the current bit as bit 0 of a word.
- `i_rdy`  in  1  consumer ready.
- `o_val`  out  `p_width`  assembled word; stable while `o_stp`=1.
- `o_stp`  out  1  word valid; held until accepted.
- `o_ovf`  out  1  overrun pulse: a completed word was dropped.
- `o_err`  out  1  sync error pulse: `i_syn` arrived mid-word.

## Operation
- States:
  - `S_HUNT`: discard bits until `i_stp & i_syn`.
  - `S_SHIFT`: accumulate bits.
- Accepted bit:
  - Shift register: `l_shf <= {i_val, l_shf[p_width-1:1]}`.
  - Bit counter `l_cnt` (0..p_width-1) increments.
- `S_HUNT` with `i_stp & i_syn`:
  - The bit is accepted as bit 0.
  - `l_cnt` becomes 1.
  - Next state is `S_SHIFT`.
- `S_HUNT` with `i_stp & ~i_syn`: bit dropped; no flags.
- `S_SHIFT`, `i_stp & ~i_syn`, `l_cnt` < p_width-1: accept the bit.
- `S_SHIFT`, `i_stp` with `l_cnt` = p_width-1 (final bit), and `i_syn`=0 on that bit: word complete.
  - `l_cnt` goes to 0.
  - Next state is `S_SHIFT` if `p_frm`=0, `S_HUNT` if `p_frm`=1.
- `S_SHIFT`, `i_stp & i_syn` with `l_cnt` ≠ 0: misalignment.
  - The partial word is discarded.
  - `o_err` pulses.
  - The bit is accepted as bit 0 of a new word; `l_cnt` becomes 1.
- `S_SHIFT`, `i_stp & i_syn` with `l_cnt` = 0: normal word start; no error.
- `i_syn` without `i_stp` is ignored in every state.
- Completed word, `{i_val, l_shf[p_width-1:1]}`, goes to the holding register:
  - Hold empty, or hold full with `i_rdy`=1 in the same cycle: load; `o_stp` stays/goes to 1.
  - Hold full with `i_rdy`=0: new word dropped; hold unchanged; `o_ovf` pulses.
- Handshake: a word is transferred in any cycle with `o_stp & i_rdy`. `o_stp` clears next cycle unless a new word loads in the same cycle.
- `o_val` only changes on a load.
- `p_width`=1 is not supported; elaboration must fail via an assertion.

## Timing
- Reset values: `o_val`=0, `o_stp`=0, `o_ovf`=0, `o_err`=0, state `S_HUNT`, `l_cnt`=0, `l_shf`=0.
- Reset asserted mid-word or mid-handshake: all state clears immediately; the partial word and the held word are lost.
- Latency: `o_stp` rises on the clock edge after the cycle in which the final bit's `i_stp` is sampled (1 cycle).
- Back-to-back: with `i_stp` held high continuously, words complete every `p_width` cycles. With `i_rdy`=1 there are no overruns.
- `o_ovf` and `o_err` are single-cycle registered pulses, asserted the cycle after the causing event.
- Both flags can pulse in the same cycle only if a sync error coincides with a drop. That cannot happen, because a sync error aborts the word.

## Structure
- Package `deserial_pkg` contains:
  - `typedef enum logic {S_HUNT, S_SHIFT} t_state`
  - Helper function for counter width: `$clog2(p_width)`.
- Sub-module `deserial_hold`: the one-entry valid/ready holding register.
  - Inputs: load strobe and word.
  - Outputs: `o_stp`, `o_val`, drop indication.
  - Same async active-low reset.
- Top level contains the FSM, bit counter, shift register and flag registers.

## Test plan
All scenarios use `p_width`=8.
- Basic word: after reset, send 0xA5 LSB first with `i_syn` on bit 0 and `i_stp` continuous, `i_rdy`=1. Expect `o_stp`=1 for one cycle, one cycle after the 8th strobe, with `o_val`=0xA5.
- Hunt: send 3 bits without sync, then 0x3C with sync. Expect only 0x3C delivered; no `o_err`.
- Free-run vs. framed:
  - `p_frm`=0: 0x01, 0x80 back-to-back with a single sync. Expect both words delivered.
  - `p_frm`=1, same stimulus. Expect 0x01 only.
- Misalignment: sync at bit 0, then sync again at bit 5, then 8 bits of 0xF0. Expect `o_err` pulse, then 0xF0 delivered.
- Overrun: `i_rdy`=0; send 0x11, then 0x22. Expect `o_val`=0x11 held and `o_ovf` pulse. Raise `i_rdy` in the same cycle as a third word 0x33 completes. Expect 0x33 loaded and no `o_ovf`.
- Async reset: assert `i_rst`=0 mid-word, between clock edges. Expect all outputs 0 immediately. After release, a new synced 0x5A is delivered correctly.

Source files
------------

// File: rtl/deserial_pkg.sv
// Shared types and helpers for the serial-to-parallel converter.
package deserial_pkg;

  typedef enum logic {S_HUNT, S_SHIFT} t_state;

  // Bit-counter width; clamped so degenerate widths still elaborate far enough to hit the width check.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/deserial_hold.sv
// One-entry valid/ready holding stage for assembled words.
module deserial_hold #(
  parameter int p_width = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ld,
  input  logic [p_width-1:0] i_wrd,
  input  logic               i_rdy,
  output logic               o_stp,
  output logic [p_width-1:0] o_val,
  output logic               o_drp
);

  // A word arriving while the held word is still pending and not being taken is lost.
  assign o_drp = i_ld & o_stp & ~i_rdy;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_stp <= 1'b0;
      o_val <= '0;
    end else if (i_ld && !o_drp) begin
      o_stp <= 1'b1;
      o_val <= i_wrd;
    end else if (i_rdy) begin
      o_stp <= 1'b0;
    end
  end

endmodule

// File: rtl/deserial.sv
// Serial-to-parallel converter: LSB-first strobed bits framed by a sync input into p_width words.
module deserial
  import deserial_pkg::*;
#(
  parameter int p_width = 8,
  parameter int p_frm   = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_val,
  input  logic               i_stp,
  input  logic               i_syn,
  input  logic               i_rdy,
  output logic [p_width-1:0] o_val,
  output logic               o_stp,
  output logic               o_ovf,
  output logic               o_err
);

  localparam int             CW   = cnt_w(p_width);
  localparam logic [CW-1:0]  LAST = CW'(p_width - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  if (p_width < 2) begin : g_width_chk
    $fatal(1, "deserial: p_width must be at least 2");
  end

  t_state               state;
  logic [CW-1:0]        cnt;
  // Only the upper p_width-1 bits are kept; the incoming bit completes the word combinationally.
  logic [p_width-1:1]   shf;
  logic [p_width-1:0]   wrd;
  logic                 ld;
  logic                 drp;

  assign wrd = {i_val, shf};
  assign ld  = i_stp & ~i_syn & (state == S_SHIFT) & (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_HUNT;
      cnt   <= '0;
      shf   <= '0;
      o_err <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      o_err <= 1'b0;
      o_ovf <= drp;
      if (i_stp) begin
        case (state)
          S_HUNT: begin
            if (i_syn) begin
              shf   <= wrd[p_width-1:1];
              cnt   <= ONE;
              state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            shf <= wrd[p_width-1:1];
            if (i_syn) begin
              // Sync on anything but bit 0 aborts the partial word and restarts framing here.
              o_err <= (cnt != '0);
              cnt   <= ONE;
            end else if (cnt == LAST) begin
              cnt <= '0;
              if (p_frm != 0) state <= S_HUNT;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

  deserial_hold #(.p_width(p_width)) u_hold (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ld  (ld),
    .i_wrd (wrd),
    .i_rdy (i_rdy),
    .o_stp (o_stp),
    .o_val (o_val),
    .o_drp (drp)
  );

endmodule

// File: tb/tb_deserial.sv
// Bench for deserial: free-running (dut0) and framed (dut1) instances share one stimulus stream.
module tb_deserial;

  logic clk = 1'b0, rst_n = 1'b0;
  logic val = 1'b0, stp = 1'b0, syn = 1'b0, rdy = 1'b0;
  logic [7:0] q_val [2];
  logic       q_stp [2];
  logic       q_ovf [2];
  logic       q_err [2];
  int checks = 0, failures = 0;

  // Reference model: bit index within the word, accumulated word, and the pending-output slot.
  logic       m_hunt [2];
  int         m_n    [2];
  logic [7:0] m_acc  [2];
  logic       e_full [2];
  logic [7:0] e_hold [2];
  logic       e_ovf  [2];
  logic       e_err  [2];

  deserial #(.p_width(8), .p_frm(0)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_val(val), .i_stp(stp), .i_syn(syn), .i_rdy(rdy),
    .o_val(q_val[0]), .o_stp(q_stp[0]), .o_ovf(q_ovf[0]), .o_err(q_err[0]));

  deserial #(.p_width(8), .p_frm(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_val(val), .i_stp(stp), .i_syn(syn), .i_rdy(rdy),
    .o_val(q_val[1]), .o_stp(q_stp[1]), .o_ovf(q_ovf[1]), .o_err(q_err[1]));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_hunt[m] = 1'b1; m_n[m] = 0; m_acc[m] = 8'h00;
      e_full[m] = 1'b0; e_hold[m] = 8'h00; e_ovf[m] = 1'b0; e_err[m] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the clock edge.
  task automatic step(input logic v, input logic s, input logic y, input logic r);
    logic       ld;
    logic [7:0] w;
    for (int m = 0; m < 2; m++) begin
      ld = 1'b0; w = 8'h00; e_ovf[m] = 1'b0; e_err[m] = 1'b0;
      if (s) begin
        if (y) begin
          if (!m_hunt[m] && m_n[m] != 0) e_err[m] = 1'b1;
          m_hunt[m] = 1'b0; m_acc[m] = 8'(v); m_n[m] = 1;
        end else if (!m_hunt[m]) begin
          m_acc[m] = m_acc[m] | (8'(v) << m_n[m]);
          m_n[m]++;
          if (m_n[m] == 8) begin
            ld = 1'b1; w = m_acc[m]; m_n[m] = 0; m_acc[m] = 8'h00;
            m_hunt[m] = (m == 1);
          end
        end
      end
      if (ld) begin
        if (!e_full[m] || r) begin e_hold[m] = w; e_full[m] = 1'b1; end
        else e_ovf[m] = 1'b1;
      end else if (r) begin
        e_full[m] = 1'b0;
      end
    end
    val = v; stp = s; syn = y; rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    val = 0; stp = 0; syn = 0; rdy = 0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_stp[m] !== 1'b0) begin failures++; $display("FAIL reset_stp dut%0d got=%b exp=0", m, q_stp[m]); end
      checks++; if (q_val[m] !== 8'h00) begin failures++; $display("FAIL reset_val dut%0d got=%h exp=00", m, q_val[m]); end
      checks++; if (q_ovf[m] !== 1'b0) begin failures++; $display("FAIL reset_ovf dut%0d got=%b exp=0", m, q_ovf[m]); end
      checks++; if (q_err[m] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b exp=0", m, q_err[m]); end
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, i == 0, 1'b1);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (q_stp[m] !== (i == 7)) begin failures++; $display("FAIL basic_stp dut%0d bit=%0d got=%b exp=%b", m, i, q_stp[m], i == 7); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_val[m] !== 8'hA5) begin failures++; $display("FAIL basic_val dut%0d got=%h exp=a5", m, q_val[m]); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_stp[m] !== 1'b0) begin failures++; $display("FAIL basic_clear dut%0d got=%b exp=0", m, q_stp[m]); end
    end
  endtask

  task automatic test_hunt();
    logic [7:0] w;
    w = 8'h3C;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b1);
      for (int m = 0; m < 2; m++) begin
        checks++; if (q_stp[m] !== 1'b0) begin failures++; $display("FAIL hunt_pre_stp dut%0d got=%b exp=0", m, q_stp[m]); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, i == 0, 1'b1);
      for (int m = 0; m < 2; m++) begin
        checks++; if (q_err[m] !== 1'b0) begin failures++; $display("FAIL hunt_err dut%0d bit=%0d got=%b exp=0", m, i, q_err[m]); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_stp[m] !== 1'b1 || q_val[m] !== 8'h3C) begin
        failures++; $display("FAIL hunt_word dut%0d got=%b/%h exp=1/3c", m, q_stp[m], q_val[m]); end
    end
  endtask

  task automatic test_frame();
    logic [7:0] a, b;
    a = 8'h01; b = 8'h80;
    do_reset();
    for (int i = 0; i < 8; i++) step(a[i], 1'b1, i == 0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_stp[m] !== 1'b1 || q_val[m] !== 8'h01) begin
        failures++; $display("FAIL frame_first dut%0d got=%b/%h exp=1/01", m, q_stp[m], q_val[m]); end
    end
    for (int i = 0; i < 8; i++) step(b[i], 1'b1, 1'b0, 1'b1);
    checks++; if (q_stp[0] !== 1'b1 || q_val[0] !== 8'h80) begin
      failures++; $display("FAIL frame_free dut0 got=%b/%h exp=1/80", q_stp[0], q_val[0]); end
    checks++; if (q_stp[1] !== 1'b0 || q_val[1] !== 8'h01) begin
      failures++; $display("FAIL frame_framed dut1 got=%b/%h exp=0/01", q_stp[1], q_val[1]); end
  endtask

  task automatic test_misalign();
    logic [7:0] w;
    w = 8'hF0;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, i == 0, 1'b1);
      for (int m = 0; m < 2; m++) begin
        checks++; if (q_err[m] !== (i == 0)) begin
          failures++; $display("FAIL mis_err dut%0d bit=%0d got=%b exp=%b", m, i, q_err[m], i == 0); end
        checks++; if (q_stp[m] !== (i == 7)) begin
          failures++; $display("FAIL mis_stp dut%0d bit=%0d got=%b exp=%b", m, i, q_stp[m], i == 7); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_val[m] !== 8'hF0) begin failures++; $display("FAIL mis_val dut%0d got=%h exp=f0", m, q_val[m]); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] a, b, c;
    a = 8'h11; b = 8'h22; c = 8'h33;
    do_reset();
    for (int i = 0; i < 8; i++) step(a[i], 1'b1, i == 0, 1'b0);
    for (int i = 0; i < 8; i++) step(b[i], 1'b1, i == 0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_ovf[m] !== 1'b1) begin failures++; $display("FAIL ovr_pulse dut%0d got=%b exp=1", m, q_ovf[m]); end
      checks++; if (q_stp[m] !== 1'b1 || q_val[m] !== 8'h11) begin
        failures++; $display("FAIL ovr_hold dut%0d got=%b/%h exp=1/11", m, q_stp[m], q_val[m]); end
    end
    for (int i = 0; i < 8; i++) begin
      step(c[i], 1'b1, i == 0, i == 7);
      for (int m = 0; m < 2; m++) begin
        checks++; if (q_ovf[m] !== 1'b0) begin failures++; $display("FAIL ovr_third dut%0d bit=%0d got=%b exp=0", m, i, q_ovf[m]); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_stp[m] !== 1'b1 || q_val[m] !== 8'h33) begin
        failures++; $display("FAIL ovr_load dut%0d got=%b/%h exp=1/33", m, q_stp[m], q_val[m]); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] a, b;
    a = 8'h77; b = 8'h5A;
    do_reset();
    for (int i = 0; i < 8; i++) step(a[i], 1'b1, i == 0, 1'b0);
    for (int i = 0; i < 3; i++) step(b[i], 1'b1, i == 0, 1'b0);
    checks++; if (q_stp[0] !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", q_stp[0]); end
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_stp[m] !== 1'b0 || q_val[m] !== 8'h00 || q_ovf[m] !== 1'b0 || q_err[m] !== 1'b0) begin
        failures++; $display("FAIL arst_clear dut%0d got=%b/%h/%b/%b exp=0/00/0/0", m, q_stp[m], q_val[m], q_ovf[m], q_err[m]); end
    end
    model_clear();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(b[i], 1'b1, i == 0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++; if (q_stp[m] !== 1'b1 || q_val[m] !== 8'h5A) begin
        failures++; $display("FAIL arst_after dut%0d got=%b/%h exp=1/5a", m, q_stp[m], q_val[m]); end
    end
  endtask

  task automatic test_random();
    logic v, s, y, r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      v = 1'($urandom_range(1));
      s = ($urandom_range(9) < 7);
      y = ($urandom_range(13) == 0);
      r = ($urandom_range(9) < 5);
      step(v, s, y, r);
      for (int m = 0; m < 2; m++) begin
        checks++; if (q_stp[m] !== e_full[m]) begin failures++; $display("FAIL rand_stp dut%0d cyc=%0d got=%b exp=%b", m, c, q_stp[m], e_full[m]); end
        checks++; if (q_val[m] !== e_hold[m]) begin failures++; $display("FAIL rand_val dut%0d cyc=%0d got=%h exp=%h", m, c, q_val[m], e_hold[m]); end
        checks++; if (q_ovf[m] !== e_ovf[m]) begin failures++; $display("FAIL rand_ovf dut%0d cyc=%0d got=%b exp=%b", m, c, q_ovf[m], e_ovf[m]); end
        checks++; if (q_err[m] !== e_err[m]) begin failures++; $display("FAIL rand_err dut%0d cyc=%0d got=%b exp=%b", m, c, q_err[m], e_err[m]); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_hunt();
    test_frame();
    test_misalign();
    test_overrun();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
